// File: rtl/conv1_win_gen.sv
// conv1_win_gen: reads the 28x28 image once in raster order and streams every valid
// KxK sliding window to the conv1 MAC array. Optional macro WIN_POS_EN adds win_row/win_col.
`ifndef WD
`define WD 7
`endif

module conv1_win_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  output logic                       cena,
  output logic [11:0]                aa,
  input  logic [`WD:0]               qa,
  output logic                       busy,
  output logic                       win_valid,
  output logic [K*K*(`WD+1)-1:0]     win_o,
  output logic                       done,
`ifdef WIN_POS_EN
  output logic [4:0]                 win_row,
  output logic [4:0]                 win_col,
`endif
  output logic [1:0]                 dbg_state
);

  localparam int PW     = `WD + 1;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int LB_LEN = (K - 1) * IMG_W;
  localparam logic [11:0] LAST_ADDR = 12'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t          state_q, state_d;
  logic            arm_q;
  logic            pix_vld_q;
  logic [11:0]     col_q, row_q;
  logic [PW-1:0]   lb    [LB_LEN];
  logic [PW-1:0]   win_sr[K][K-1];
  logic [PW-1:0]   win_nx[K][K];
  logic [K*K*PW-1:0] win_flat;
  logic            win_hit;
  logic            run_go;

  // Handshake: win_valid has no ready; the consumer must take win_o in every cycle
  // win_valid=1, and win_o holds its last window otherwise.

  // arm_q blocks a start that coincides with the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && arm_q) state_d = READ;
      READ:    if (aa == LAST_ADDR) state_d = DRAIN;
      DRAIN:   if (!pix_vld_q) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign run_go    = (state_q == IDLE) && (state_d == READ);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign dbg_state = state_q;

  // Read port: address n is presented in the cycle after it is chosen; data returns one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cena      <= 1'b1;
      aa        <= '0;
      pix_vld_q <= 1'b0;
    end else begin
      cena      <= (state_d != READ);
      pix_vld_q <= ~cena;
      if (run_go)
        aa <= '0;
      else if ((state_q == READ) && (state_d == READ))
        aa <= aa + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q <= '0;
      row_q <= '0;
    end else if (run_go) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pix_vld_q) begin
      if (col_q == 12'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= (row_q == 12'(IMG_H - 1)) ? '0 : row_q + 12'd1;
      end else begin
        col_q <= col_q + 12'd1;
      end
    end
  end

  // lb[j] holds the pixel that arrived j+1 pixels ago, so lb[k*IMG_W-1] is k rows up.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LB_LEN; i++) lb[i] <= '0;
    end else if (pix_vld_q) begin
      lb[0] <= qa;
      for (int i = 1; i < LB_LEN; i++) lb[i] <= lb[i-1];
    end
  end

  always_comb begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_nx[r][c] = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K - 1; c++)
        win_nx[r][c] = win_sr[r][c];
    for (int r = 0; r < K - 1; r++)
      win_nx[r][K-1] = lb[(K - 1 - r) * IMG_W - 1];
    win_nx[K-1][K-1] = qa;
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_flat[(r*K + c)*PW +: PW] = win_nx[r][c];
  end

  assign win_hit = pix_vld_q && (row_q >= 12'(K - 1)) && (col_q >= 12'(K - 1));

  // win_sr keeps the K-1 rightmost columns of the latest window for the next shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K - 1; c++)
          win_sr[r][c] <= '0;
    end else if (pix_vld_q) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K - 1; c++)
          win_sr[r][c] <= win_nx[r][c+1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_valid <= 1'b0;
      win_o     <= '0;
    end else begin
      win_valid <= win_hit;
      if (win_hit) win_o <= win_flat;
    end
  end

`ifdef WIN_POS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_row <= '0;
      win_col <= '0;
    end else if (win_hit) begin
      win_row <= 5'(row_q - 12'(K - 1));
      win_col <= 5'(col_q - 12'(K - 1));
    end
  end
`endif

endmodule
